// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg
//   Shared constants and helpers for the multi-channel clock divider.
//   - DIV_DISABLED / DIV_ENABLE_ONLY: the two special divisor values.
//   - clkdiv_start(): start count used on apply/sync.
//   - clkdiv_params_ok(): elaboration-time parameter range check.
//   Optional feature macro: CLKDIV_PHASE_EN (programmable start phase).
package clkdiv_pkg;

  localparam int DIV_DISABLED    = 0;  // channel stopped, outputs low
  localparam int DIV_ENABLE_ONLY = 1;  // tick/clk_out held high
  localparam int MAX_CHANNELS    = 8;
  localparam int MAX_WIDTH       = 32;

  // Start count for a fresh period: the requested phase if it falls inside
  // the period, otherwise the period start. Operands are zero-extended to
  // MAX_WIDTH by the caller so one function serves every WIDTH.
  function automatic logic [MAX_WIDTH-1:0] clkdiv_start(
    input logic [MAX_WIDTH-1:0] q,
    input logic [MAX_WIDTH-1:0] p
  );
    return (q < p) ? q : '0;
  endfunction

  function automatic bit clkdiv_params_ok(
    input int          channels,
    input int          width,
    input int unsigned reset_div
  );
    longint unsigned rd;
    rd = longint'(reset_div);
    return (channels >= 1) && (channels <= MAX_CHANNELS) &&
           (width >= 1) && (width <= MAX_WIDTH) &&
           ((rd >> width) == 0);
  endfunction

endpackage

// File: rtl/clock_divider_multi_channel.sv
// clkdiv_channel
//   One divider channel: counter C, active divisor D, pending divisor P,
//   pending phase Q (CLKDIV_PHASE_EN only), busy flag, registered outputs.
// Ports
//   clock_in  : fast clock, rising edge
//   reset_n   : synchronous active-low reset
//   sync      : restart this channel (applies any pending value first)
//   divisor   : requested divisor, captured on update
//   phase     : requested start count (CLKDIV_PHASE_EN only)
//   update    : capture strobe for divisor/phase
//   busy      : pending value captured, not yet applied
//   clk_out   : divided clock (registered)
//   tick      : one-cycle pulse per divided period (registered)
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             sync,
  input  logic [WIDTH-1:0] divisor,
`ifdef CLKDIV_PHASE_EN
  input  logic [WIDTH-1:0] phase,
`endif
  input  logic             update,
  output logic             busy,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] D_OFF = WIDTH'(DIV_DISABLED);
  localparam logic [WIDTH-1:0] D_ONE = WIDTH'(DIV_ENABLE_ONLY);
  localparam logic [WIDTH-1:0] D_RST = WIDTH'(RESET_DIV);

  logic [WIDTH-1:0] cnt_q, div_q, pdiv_q;
  logic [WIDTH-1:0] div_nxt, cnt_nxt, start;
  logic             last, apply;
`ifdef CLKDIV_PHASE_EN
  logic [WIDTH-1:0] pph_q;
`endif

  always_comb begin
    // D-1 only matters when D >= 2; the guard keeps the wrapped value inert.
    last    = (div_q > D_ONE) && (cnt_q == div_q - WIDTH'(1));
    // D <= 1 has no period boundary, so a pending value applies at once.
    apply   = busy && (sync || last || (div_q <= D_ONE));
    div_nxt = apply ? pdiv_q : div_q;
`ifdef CLKDIV_PHASE_EN
    start   = WIDTH'(clkdiv_start(MAX_WIDTH'(pph_q), MAX_WIDTH'(div_nxt)));
`else
    start   = '0;
`endif
    if (sync || apply)       cnt_nxt = start;
    else if (div_q <= D_ONE) cnt_nxt = '0;
    else if (last)           cnt_nxt = '0;
    else                     cnt_nxt = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      div_q   <= D_RST;
      pdiv_q  <= '0;
`ifdef CLKDIV_PHASE_EN
      pph_q   <= '0;
`endif
      busy    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      div_q <= div_nxt;
      // Outputs follow the pre-edge counter, so a divisor change only ever
      // takes effect on a period boundary and never chops a phase short.
      if (div_q == D_OFF)      clk_out <= 1'b0;
      else if (div_q == D_ONE) clk_out <= 1'b1;
      else                     clk_out <= (cnt_q >= (div_q >> 1));
      tick <= !sync && ((div_q == D_ONE) || last);
      // A fresh capture wins over the apply on the same edge: the old value
      // goes active and the new one stays pending.
      if (update) begin
        pdiv_q <= divisor;
`ifdef CLKDIV_PHASE_EN
        pph_q  <= phase;
`endif
        busy   <= 1'b1;
      end else if (apply) begin
        busy   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi
//   CHANNELS independent glitch-free clock dividers off one fast clock, each
//   with a one-cycle tick enable. Optional macro CLKDIV_PHASE_EN adds the
//   phase port for programmable start offsets.
// Ports
//   clock_in : fast clock
//   reset_n  : synchronous active-low reset
//   sync     : restart all channels on the next edge
//   divisor  : CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   phase    : CHANNELS*WIDTH start counts (CLKDIV_PHASE_EN only)
//   update   : per-channel capture strobe
//   busy     : per-channel pending flag
//   clk_out  : per-channel divided clock
//   tick     : per-channel period pulse
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int          CHANNELS  = 2,
  parameter int          WIDTH     = 16,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic                      clock_in,
  input  logic                      reset_n,
  input  logic                      sync,
  input  logic [CHANNELS*WIDTH-1:0] divisor,
`ifdef CLKDIV_PHASE_EN
  input  logic [CHANNELS*WIDTH-1:0] phase,
`endif
  input  logic [CHANNELS-1:0]       update,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick
);

  localparam bit PARAMS_OK = clkdiv_params_ok(CHANNELS, WIDTH, RESET_DIV);

  generate
    if (!PARAMS_OK) begin : g_param_err
      $error("clock_divider_multi: CHANNELS/WIDTH/RESET_DIV out of range");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      clkdiv_channel #(
        .WIDTH     (WIDTH),
        .RESET_DIV (RESET_DIV)
      ) u_ch (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .sync     (sync),
        .divisor  (divisor[i*WIDTH +: WIDTH]),
`ifdef CLKDIV_PHASE_EN
        .phase    (phase[i*WIDTH +: WIDTH]),
`endif
        .update   (update[i]),
        .busy     (busy[i]),
        .clk_out  (clk_out[i]),
        .tick     (tick[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed checks plus randomized traffic
// against a period-level reference model.
module tb_clock_divider_multi;

  localparam int CH      = 3;
  localparam int W       = 8;
  localparam int RST_DIV = 2;
`ifdef CLKDIV_PHASE_EN
  localparam bit PH_EN = 1'b1;
`else
  localparam bit PH_EN = 1'b0;
`endif

  logic            clock_in = 1'b0;
  logic            reset_n  = 1'b0;
  logic            sync     = 1'b0;
  logic [CH*W-1:0] divisor  = '0;
  logic [CH*W-1:0] phase    = '0;
  logic [CH-1:0]   update   = '0;
  logic [CH-1:0]   busy, clk_out, tick;

  always #5 clock_in = ~clock_in;

  clock_divider_multi #(.CHANNELS(CH), .WIDTH(W), .RESET_DIV(RST_DIV)) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .sync     (sync),
    .divisor  (divisor),
`ifdef CLKDIV_PHASE_EN
    .phase    (phase),
`endif
    .update   (update),
    .busy     (busy),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference model: each channel is a period of length m_len with the
  // current position m_at inside it; pending request in m_plen/m_pph.
  int m_len[CH], m_at[CH], m_plen[CH], m_pph[CH];
  bit m_pend[CH];
  bit e_clk[CH], e_tick[CH];

  task automatic model_step();
    for (int ch = 0; ch < CH; ch++) begin
      int  len, at, first;
      bit  wrap, take;
      if (!reset_n) begin
        m_len[ch] = RST_DIV; m_at[ch] = 0; m_plen[ch] = 0; m_pph[ch] = 0;
        m_pend[ch] = 0; e_clk[ch] = 0; e_tick[ch] = 0;
        continue;
      end
      len  = m_len[ch];
      at   = m_at[ch];
      wrap = (len >= 2) && (at == len - 1);
      // Outputs shown after this edge describe the position before it.
      e_clk[ch]  = (len == 0) ? 1'b0 : (len == 1) ? 1'b1 : (at >= len / 2);
      e_tick[ch] = !sync && ((len == 1) || wrap);
      take = m_pend[ch] && (sync || wrap || len <= 1);
      if (take) len = m_plen[ch];
      first = (PH_EN && m_pph[ch] < len) ? m_pph[ch] : 0;
      if (sync || take)  at = first;
      else if (len >= 2) at = (at + 1) % len;
      else               at = 0;
      m_len[ch] = len;
      m_at[ch]  = at;
      if (update[ch]) begin
        m_plen[ch] = int'(divisor[ch*W +: W]);
        m_pph[ch]  = int'(phase[ch*W +: W]);
        m_pend[ch] = 1'b1;
      end else if (take) begin
        m_pend[ch] = 1'b0;
      end
    end
  endtask

  // One clock: model advances at the edge, outputs compared 1 time unit
  // later, then single-cycle strobes are dropped.
  task automatic cycle();
    @(posedge clock_in);
    model_step();
    #1;
    for (int ch = 0; ch < CH; ch++) begin
      chk($sformatf("busy[%0d]", ch), 32'(busy[ch]),    32'(m_pend[ch]));
      chk($sformatf("clk[%0d]", ch),  32'(clk_out[ch]), 32'(e_clk[ch]));
      chk($sformatf("tick[%0d]", ch), 32'(tick[ch]),    32'(e_tick[ch]));
    end
    update = '0;
    sync   = 1'b0;
  endtask

  task automatic set_div(input int ch, input int d, input int ph);
    divisor[ch*W +: W] = W'(d);
    phase[ch*W +: W]   = W'(ph);
    update[ch]         = 1'b1;
  endtask

  task automatic wait_idle(input int ch);
    int k;
    k = 0;
    while (busy[ch] && k < 400) begin cycle(); k++; end
    chk($sformatf("idle_timeout[%0d]", ch), 32'(busy[ch]), 32'd0);
  endtask

  // Tick-to-tick period with clk_out low/high cycle counts inside it.
  task automatic measure(input int ch, output int per, output int lo, output int hi);
    int k;
    k = 0; per = 0; lo = 0; hi = 0;
    while (!tick[ch] && k < 600) begin cycle(); k++; end
    k = 0;
    do begin
      cycle(); per++; k++;
      if (clk_out[ch]) hi++; else lo++;
    end while (!tick[ch] && k < 600);
  endtask

  initial begin
    int per, lo, hi, t, tg, nb, t0, t1, k;
    bit prev;

    // Reset held 3 cycles: all outputs low.
    reset_n = 1'b0;
    repeat (3) cycle();
    chk("rst_outputs", 32'({busy, clk_out, tick}), 32'd0);
    reset_n = 1'b1;

    // RESET_DIV=2: clk_out toggles every cycle, tick every 2nd cycle.
    t = 0; tg = 0; prev = clk_out[0];
    repeat (8) begin
      cycle();
      t += int'(tick[0]);
      if (clk_out[0] != prev) tg++;
      prev = clk_out[0];
    end
    chk("rst_d2_ticks", t, 4);
    chk("rst_d2_toggles", tg, 7);

    // Even and odd divisors.
    set_div(0, 4, 0); set_div(1, 5, 0);
    cycle();
    wait_idle(0); wait_idle(1);
    measure(0, per, lo, hi);
    chk("d4_period", per, 4); chk("d4_low", lo, 2); chk("d4_high", hi, 2);
    measure(1, per, lo, hi);
    chk("d5_period", per, 5); chk("d5_low", lo, 2); chk("d5_high", hi, 3);

    // Divisor 1: tick and clk_out held high.
    set_div(2, 1, 0);
    cycle();
    wait_idle(2);
    cycle();
    repeat (5) begin
      cycle();
      chk("d1_tick", 32'(tick[2]), 32'd1);
      chk("d1_clk", 32'(clk_out[2]), 32'd1);
    end

    // Divisor 0: channel off.
    set_div(1, 0, 0);
    cycle();
    wait_idle(1);
    cycle();
    repeat (5) begin
      cycle();
      chk("d0_tick", 32'(tick[1]), 32'd0);
      chk("d0_clk", 32'(clk_out[1]), 32'd0);
    end

    // Glitch-free change: D=10, update arrives so busy rises with C=3.
    set_div(0, 10, 0);
    cycle();
    wait_idle(0);
    k = 0;
    while (m_at[0] != 2 && k < 40) begin cycle(); k++; end
    set_div(0, 3, 0);
    cycle();
    nb = 0;
    for (int i = 0; i < 50 && busy[0]; i++) begin nb++; cycle(); end
    chk("glitch_busy_cycles", nb, 7);
    measure(0, per, lo, hi);
    chk("glitch_new_period", per, 3);

    // Sync: ch0 phase 0, ch1 phase 2, both D=8.
    set_div(0, 8, 0); set_div(1, 8, 2);
    cycle();
    wait_idle(0); wait_idle(1);
    sync = 1'b1;
    cycle();
    t0 = -1; t1 = -1;
    for (int i = 1; i <= 40 && (t0 < 0 || t1 < 0); i++) begin
      cycle();
      if (tick[0] && t0 < 0) t0 = i;
      if (tick[1] && t1 < 0) t1 = i;
    end
    chk("sync_tick_ch0", t0, 8);
    chk("sync_tick_offset", t0 - t1, PH_EN ? 2 : 0);

    // Phase beyond the period falls back to 0.
    set_div(1, 8, 9);
    cycle();
    wait_idle(1);
    sync = 1'b1;
    cycle();
    t0 = -1; t1 = -1;
    for (int i = 1; i <= 40 && (t0 < 0 || t1 < 0); i++) begin
      cycle();
      if (tick[0] && t0 < 0) t0 = i;
      if (tick[1] && t1 < 0) t1 = i;
    end
    chk("phase_oob_offset", t0 - t1, 0);

    // Collision: second update on the apply edge keeps busy high.
    set_div(0, 4, 0);
    cycle();
    wait_idle(0);
    set_div(0, 6, 0);
    cycle();
    k = 0;
    while (m_at[0] != 3 && k < 40) begin cycle(); k++; end
    set_div(0, 5, 0);
    cycle();
    chk("coll_busy_held", 32'(busy[0]), 32'd1);
    wait_idle(0);
    measure(0, per, lo, hi);
    chk("coll_final_period", per, 5);

    // Reset mid-period discards a pending value.
    set_div(0, 9, 0);
    cycle();
    reset_n = 1'b0;
    cycle();
    chk("rst_mid_outputs", 32'({busy, clk_out, tick}), 32'd0);
    reset_n = 1'b1;
    measure(0, per, lo, hi);
    chk("rst_mid_period", per, RST_DIV);

    // Maximum divisor for this width.
    set_div(2, 255, 0);
    cycle();
    wait_idle(2);
    measure(2, per, lo, hi);
    chk("dmax_period", per, 255); chk("dmax_low", lo, 127); chk("dmax_high", hi, 128);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(0, 9) == 0) begin
          int r, d;
          r = int'($urandom_range(0, 15));
          if (r < 2)        d = r;
          else if (r == 15) d = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(20, 40));
          else              d = int'($urandom_range(2, 20));
          set_div(ch, d, int'($urandom_range(0, 24)));
        end
      end
      sync    = ($urandom_range(0, 49) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      cycle();
      reset_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
